// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider and its receive-side period meter.
//   CNT_W          : count width shared with the divider's half-period counter
//   meter_state_t  : period meter FSM encoding
package clkdiv_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a both-edge detector for asynchronous
// single-bit inputs (slow clocks, buttons, strobes).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   d_async  : asynchronous input
//   level    : synchronized level (registered)
//   edge_c   : combinational one-cycle pulse on either transition of level
//              ("edge" itself is a reserved word)
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one-cycle delayed copy of the synchronized level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign edge_c = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the half-period of a slow square wave in clk cycles, i.e. recovers
// the count N of a divider that toggles its output every N cycles.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   sig_in      : slow square wave, asynchronous to clk
//   meas_en     : 1 = measure, 0 = idle (state cleared, half_period held)
//   half_period : last measured edge-to-edge interval
//   valid       : one-cycle pulse when half_period is updated
//   locked      : consecutive measurements agree within TOL
//   stalled     : sticky timeout flag, cleared by rst, new valid or meas_en low
module period_meter
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16'hFFFF,
    parameter int unsigned TOL         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [WIDTH-1:0] half_period,
    output logic             valid,
    output logic             locked,
    output logic             stalled
);

    // Measurement and difference are carried one bit wider so nothing wraps
    localparam int unsigned EXT_W = WIDTH + 1;

    meter_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hp_q, hp_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;
    logic             have_meas_q, have_meas_d;

    logic             sig_edge;
    logic             sig_level_unused;

    logic [EXT_W-1:0] meas_w;
    logic [EXT_W-1:0] hp_ext;
    logic [EXT_W-1:0] diff_w;
    logic             within_tol;
    logic             timeout_hit;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .level   (sig_level_unused),
        .edge_c  (sig_edge)
    );

    // Current interval length and its distance from the previous result
    always_comb begin
        meas_w      = EXT_W'(cnt_q) + EXT_W'(1);
        hp_ext      = EXT_W'(hp_q);
        diff_w      = (meas_w >= hp_ext) ? (meas_w - hp_ext) : (hp_ext - meas_w);
        within_tol  = (diff_w <= EXT_W'(TOL));
        timeout_hit = (meas_w == EXT_W'(TIMEOUT));
    end

    // Next-state and output logic; edge has priority over timeout in MEAS
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hp_d        = hp_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        stalled_d   = stalled_q;
        have_meas_d = have_meas_q;

        if (!meas_en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            locked_d    = 1'b0;
            stalled_d   = 1'b0;
            have_meas_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    // First interval after arming is partial and never reported
                    cnt_d       = '0;
                    have_meas_d = 1'b0;
                    if (sig_edge) begin
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (sig_edge) begin
                        hp_d        = meas_w[WIDTH-1:0];
                        valid_d     = 1'b1;
                        stalled_d   = 1'b0;
                        cnt_d       = '0;
                        locked_d    = have_meas_q && within_tol;
                        have_meas_d = 1'b1;
                    end else if (timeout_hit) begin
                        stalled_d   = 1'b1;
                        locked_d    = 1'b0;
                        cnt_d       = '0;
                        have_meas_d = 1'b0;
                        state_d     = ARM;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hp_q        <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            stalled_q   <= 1'b0;
            have_meas_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hp_q        <= hp_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            stalled_q   <= stalled_d;
            have_meas_q <= have_meas_d;
        end
    end

    assign half_period = hp_q;
    assign valid       = valid_q;
    assign locked      = locked_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: reset, steady period, tolerance lock,
// timeout/restart, meas_en drop and mid-measurement reset.
module tb_period_meter;
    import clkdiv_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 20;
    localparam int unsigned TL = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         sig_in;
    logic         meas_en;
    logic [W-1:0] half_period;
    logic         valid;
    logic         locked;
    logic         stalled;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned tog_cyc = 0;
    int unsigned mark    = 0;
    int unsigned stall_cyc;

    int unsigned vq_hp[$];
    int unsigned vq_lk[$];
    int unsigned vq_st[$];
    int unsigned vq_cyc[$];

    period_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO),
        .TOL         (TL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .meas_en     (meas_en),
        .half_period (half_period),
        .valid       (valid),
        .locked      (locked),
        .stalled     (stalled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every valid pulse with the outputs that accompany it
    always @(negedge clk) begin
        if (valid) begin
            vq_hp.push_back(32'(half_period));
            vq_lk.push_back(32'(locked));
            vq_st.push_back(32'(stalled));
            vq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle_after(input int unsigned gap);
        step(gap);
        sig_in  = ~sig_in;
        tog_cyc = cyc;
    endtask

    task automatic pop_valid(input string tag, input int unsigned hp, input int unsigned lk);
        int unsigned got_hp = 32'hFFFF_FFFF;
        int unsigned got_lk = 32'hFFFF_FFFF;
        if (vq_hp.size() != 0) begin
            got_hp = vq_hp.pop_front();
            got_lk = vq_lk.pop_front();
            void'(vq_st.pop_front());
            void'(vq_cyc.pop_front());
        end
        check({tag, "_hp"}, got_hp, hp);
        check({tag, "_lk"}, got_lk, lk);
    endtask

    task automatic check_idle_outputs(input string tag, input int unsigned hp);
        check({tag, "_hp"},      32'(half_period), hp);
        check({tag, "_valid"},   32'(valid),       0);
        check({tag, "_locked"},  32'(locked),      0);
        check({tag, "_stalled"}, 32'(stalled),     0);
    endtask

    initial begin
        // 1: reset with sig_in toggling
        rst     = 1'b1;
        meas_en = 1'b0;
        sig_in  = 1'b0;
        repeat (3) begin
            step(1);
            sig_in = ~sig_in;
        end
        sig_in = 1'b0;
        step(1);
        check_idle_outputs("t1", 0);
        check("t1_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;

        // 2: steady period 5
        meas_en = 1'b1;
        step(2);
        toggle_after(0);
        toggle_after(5);
        mark = tog_cyc;
        repeat (4) toggle_after(5);
        step(4);
        check("t2_nvalid", vq_hp.size(), 5);
        check("t2_first_cyc", vq_cyc[0], mark + 3);
        for (int i = 1; i < 5; i++) begin
            check("t2_spacing", vq_cyc[i] - vq_cyc[i-1], 5);
        end
        pop_valid("t2_v1", 5, 0);
        for (int i = 0; i < 4; i++) pop_valid("t2_vn", 5, 1);

        // 3: intervals 5, 6, 8 with TOL=1
        toggle_after(1);
        toggle_after(6);
        toggle_after(8);
        step(4);
        check("t3_nvalid", vq_hp.size(), 3);
        pop_valid("t3_p5", 5, 1);
        pop_valid("t3_p6", 6, 1);
        pop_valid("t3_p8", 8, 0);

        // 4: relock at 5, then stop and wait for the timeout
        toggle_after(1);
        toggle_after(5);
        mark      = tog_cyc;
        stall_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stalled) begin
                stall_cyc = cyc;
                break;
            end
        end
        check("t4_stall_cyc", stall_cyc, mark + 3 + TO);
        check("t4_locked", 32'(locked), 0);
        check("t4_hp", 32'(half_period), 5);
        check("t4_nvalid", vq_hp.size(), 2);
        pop_valid("t4_p5a", 5, 0);
        pop_valid("t4_p5b", 5, 1);
        step(1);
        toggle_after(2);
        step(4);
        check("t4_arm_novalid", vq_hp.size(), 0);
        check("t4_stall_held", 32'(stalled), 1);
        toggle_after(3);
        step(4);
        check("t4_restart_n", vq_hp.size(), 1);
        check("t4_st_at_valid", vq_st[0], 0);
        pop_valid("t4_p7", 7, 0);
        check("t4_stall_clr", 32'(stalled), 0);

        // 5: meas_en dropped mid-interval for 10 cycles, then period 3
        toggle_after(3);
        step(4);
        pop_valid("t5_p7", 7, 1);
        meas_en = 1'b0;
        toggle_after(4);
        step(6);
        check("t5_low_nvalid", vq_hp.size(), 0);
        check_idle_outputs("t5_low", 7);
        meas_en = 1'b1;
        toggle_after(2);
        toggle_after(3);
        mark = tog_cyc;
        toggle_after(3);
        step(4);
        check("t5_nvalid", vq_hp.size(), 2);
        check("t5_first_cyc", vq_cyc[0], mark + 3);
        pop_valid("t5_p3a", 3, 0);
        pop_valid("t5_p3b", 3, 1);

        // 6: reset pulse during MEAS at period 4
        toggle_after(0);
        toggle_after(4);
        step(4);
        pop_valid("t6_p4a", 4, 1);
        pop_valid("t6_p4b", 4, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_idle_outputs("t6_rst", 0);
        check("t6_state", 32'(dut.state_q), 32'(IDLE));
        toggle_after(2);
        toggle_after(4);
        mark = tog_cyc;
        step(4);
        check("t6_nvalid", vq_hp.size(), 1);
        check("t6_cyc", vq_cyc[0], mark + 3);
        pop_valid("t6_p4", 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
